// File: rtl/neuromorphic_bridge_pkg.sv
// neuromorphic_bridge_pkg: register map, response code and datapath widths for the neuron bridge.
package neuromorphic_bridge_pkg;
  // Word offsets, decoded from ADDR[3:2].
  typedef enum logic [1:0] {
    CTRL   = 2'd0,
    WEIGHT = 2'd1,
    THRESH = 2'd2,
    STATUS = 2'd3
  } reg_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int POT_W = 24;
  localparam int WEIGHT_W = 16;
endpackage

// File: rtl/neuromorphic_asic_bridge_top_lif_neuron_core.sv
// lif_neuron_core: pwm_clk synchronizer, tick detect, saturating integrate-and-fire accumulator.
module lif_neuron_core
  import neuromorphic_bridge_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rst_i,
  input  logic                pwm_i,
  input  logic                en_i,
  input  logic [WEIGHT_W-1:0] weight_i,
  input  logic [POT_W-1:0]    thresh_i,
  output logic [POT_W-1:0]    pot_o,
  output logic                digit_o
);
  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] holds the previous synchronized level.
  logic [2:0]       sync_q, sync_d;
  logic [POT_W-1:0] pot_q, pot_d, sat;
  logic [POT_W:0]   sum;
  logic             digit_q, digit_d, tick, fire;
  always_comb begin
    tick = sync_q[1] & ~sync_q[2];
    sum = {1'b0, pot_q} + {{(POT_W + 1 - WEIGHT_W){1'b0}}, weight_i};
    sat = sum[POT_W] ? '1 : sum[POT_W-1:0];
    fire = (thresh_i != '0) && (sat >= thresh_i);
    sync_d = rst_i ? '0 : {sync_q[1:0], pwm_i};
    pot_d = rst_i ? '0 : (tick && en_i) ? (fire ? '0 : sat) : pot_q;
    digit_d = ~rst_i & tick & en_i & fire;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      pot_q   <= '0;
      digit_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pot_q   <= pot_d;
      digit_q <= digit_d;
    end
  end
  assign pot_o = pot_q;
  assign digit_o = digit_q;
endmodule

// File: rtl/neuromorphic_asic_bridge_top.sv
// neuromorphic_asic_bridge_top: AXI4-Lite register file fronting one integrate-and-fire neuron core.
module neuromorphic_asic_bridge_top
  import neuromorphic_bridge_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pwm_clk,
  output logic                            digit,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  logic [DW-1:0]    ctrl_q, ctrl_d, weight_q, weight_d, thresh_q, thresh_d, rdata_q, rdata_d, status;
  logic             awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic             wr_en, rd_en;
  logic [POT_W-1:0] pot;
  reg_e             wsel, rsel;
  logic             unused;
  assign unused = &{1'b0, clk, S_AXI_WSTRB, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                    S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};
  always_comb begin
    wsel = reg_e'(S_AXI_AWADDR[3:2]);
    rsel = reg_e'(S_AXI_ARADDR[3:2]);
    wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_en = arready_q & S_AXI_ARVALID;
    // Address and data are accepted together, and never while a response is still pending.
    awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    bvalid_d = wr_en | (bvalid_q & ~S_AXI_BREADY);
    arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
    rvalid_d = rd_en | (rvalid_q & ~S_AXI_RREADY);
    status = {digit, {(DW - 1 - POT_W){1'b0}}, pot};
    rdata_d = !rd_en ? rdata_q :
              rsel == CTRL ? ctrl_q :
              rsel == WEIGHT ? weight_q :
              rsel == THRESH ? thresh_q : status;
    ctrl_d = (wr_en && wsel == CTRL) ? S_AXI_WDATA : ctrl_q;
    weight_d = (wr_en && wsel == WEIGHT) ? S_AXI_WDATA : weight_q;
    thresh_d = (wr_en && wsel == THRESH) ? S_AXI_WDATA : thresh_q;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      weight_q  <= '0;
      thresh_q  <= '0;
      rdata_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      weight_q  <= weight_d;
      thresh_q  <= thresh_d;
      rdata_q   <= rdata_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = awready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = RESP_OKAY;
  lif_neuron_core u_core (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .rst_i   (rst),
    .pwm_i   (pwm_clk),
    .en_i    (ctrl_q[0]),
    .weight_i(weight_q[WEIGHT_W-1:0]),
    .thresh_i(thresh_q[POT_W-1:0]),
    .pot_o   (pot),
    .digit_o (digit)
  );
endmodule

// File: tb/tb_neuromorphic_asic_bridge_top.sv
// tb_neuromorphic_asic_bridge_top: register vector table, hand-written AXI corner cases and a randomized neuron model.
module tb_neuromorphic_asic_bridge_top;
  logic        S_AXI_ACLK = 1'b0, S_AXI_ARESETN = 1'b0, rst = 1'b0, pwm_clk = 1'b0, digit;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0, S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;

  neuromorphic_asic_bridge_top dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .clk(S_AXI_ACLK), .rst(rst),
    .pwm_clk(pwm_clk), .digit(digit),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int vecs = 0, miss = 0, spikes = 0;
  always @(negedge S_AXI_ACLK) if (digit) spikes <= spikes + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'h0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    chk("awready", {31'b0, S_AXI_AWREADY}, 32'd1);
    chk("wready", {31'b0, S_AXI_WREADY}, 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("awready_1cyc", {31'b0, S_AXI_AWREADY}, 32'd0);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge S_AXI_ACLK); n++; end
    chk("bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    chk("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
    @(negedge S_AXI_ACLK);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge S_AXI_ACLK); n++; end
    chk("rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
    chk("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
    d = S_AXI_RDATA;
    @(negedge S_AXI_ACLK);
  endtask

  task automatic pwm_tick();
    pwm_clk = 1'b1;
    repeat (3) @(negedge S_AXI_ACLK);
    pwm_clk = 1'b0;
    repeat (3) @(negedge S_AXI_ACLK);
  endtask

  // Reference neuron: plain integer arithmetic on the architectural rules.
  longint pot_m = 0;
  logic   en_m = 1'b0;
  longint w_m = 0, th_m = 0;
  task automatic model_tick(output int fired);
    longint s;
    fired = 0;
    if (en_m) begin
      s = pot_m + w_m;
      if (s > 64'hFFFFFF) s = 64'hFFFFFF;
      if (th_m != 0 && s >= th_m) begin
        pot_m = 0;
        fired = 1;
      end else pot_m = s;
    end
  endtask

  typedef struct {
    logic [31:0] waddr, wdata, raddr, exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [31:0] d;
    int n, s0, f;
    tbl[0] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{32'h4, 32'hDEADBEEF, 32'h4, 32'hDEADBEEF};
    tbl[2] = '{32'h8, 32'hDEADBEEF, 32'h8, 32'hDEADBEEF};
    tbl[3] = '{32'hC, 32'hFFFFFFFF, 32'hC, 32'h00000000};
    tbl[4] = '{32'h14, 32'h0000A5A5, 32'h4, 32'h0000A5A5};
    tbl[5] = '{32'hF0000008, 32'h01234567, 32'h8, 32'h01234567};
    tbl[6] = '{32'h0, 32'h00000000, 32'h10, 32'h00000000};
    tbl[7] = '{32'h4, 32'hDEADBEEF, 32'h4, 32'hDEADBEEF};

    repeat (3) @(negedge S_AXI_ACLK);
    chk("rst_ready_valid", {26'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, digit}, 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_resp", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
    axi_read(32'hC, d); chk("rst_status", d, 32'd0);
    axi_read(32'h8, d); chk("rst_thresh", d, 32'd0);

    for (int i = 0; i < 8; i++) begin
      axi_write(tbl[i].waddr, tbl[i].wdata);
      axi_read(tbl[i].raddr, d);
      chk($sformatf("tbl%0d", i), d, tbl[i].exp);
    end

    // Read response held while RREADY is low.
    S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0;
    repeat (5) begin
      chk("hold_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
      chk("hold_rdata", S_AXI_RDATA, 32'hDEADBEEF);
      @(negedge S_AXI_ACLK);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("rvalid_drop", {31'b0, S_AXI_RVALID}, 32'd0);

    // Simultaneous write and read of WEIGHT: the read sees the old value.
    S_AXI_AWADDR = 32'h4; S_AXI_WDATA = 32'h00000055; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    chk("sim_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("sim_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
    chk("sim_rdata_old", S_AXI_RDATA, 32'hDEADBEEF);
    chk("sim_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    @(negedge S_AXI_ACLK);
    axi_read(32'h4, d); chk("sim_rdata_new", d, 32'h00000055);

    // Response held while BREADY is low; held valids must not start a second write.
    S_AXI_AWADDR = 32'h0; S_AXI_WDATA = 32'h12345678; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    @(negedge S_AXI_ACLK);
    repeat (6) begin
      chk("bhold_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
      chk("bhold_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
      @(negedge S_AXI_ACLK);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("bvalid_drop", {31'b0, S_AXI_BVALID}, 32'd0);
    axi_read(32'h0, d); chk("bhold_ctrl", d, 32'h12345678);

    // Integrate and fire with WEIGHT=0x10, THRESH=0x30.
    axi_write(32'h0, 32'h1); axi_write(32'h4, 32'h10); axi_write(32'h8, 32'h30);
    pwm_tick(); axi_read(32'hC, d); chk("pot_1", d, 32'h10);
    pwm_tick(); axi_read(32'hC, d); chk("pot_2", d, 32'h20);
    pwm_clk = 1'b1;
    @(negedge S_AXI_ACLK); chk("digit_c1", {31'b0, digit}, 32'd0);
    @(negedge S_AXI_ACLK); chk("digit_c2", {31'b0, digit}, 32'd0);
    @(negedge S_AXI_ACLK); chk("digit_c3", {31'b0, digit}, 32'd1);
    @(negedge S_AXI_ACLK); chk("digit_c4", {31'b0, digit}, 32'd0);
    pwm_clk = 1'b0;
    repeat (3) @(negedge S_AXI_ACLK);
    axi_read(32'hC, d); chk("pot_fire_clear", d, 32'h0);

    // Randomized weights/thresholds against the reference neuron.
    pot_m = 0;
    for (int it = 0; it < 6; it++) begin
      logic [31:0] c, w, t;
      c = $urandom; c[0] = (it != 2);
      w = $urandom;
      t = $urandom & 32'hFF03FFFF;
      if (it == 4) t[23:0] = 24'h0;
      axi_write(32'h0, c); axi_write(32'h4, w); axi_write(32'h8, t);
      en_m = c[0]; w_m = longint'(w[15:0]); th_m = longint'(t[23:0]);
      for (int k = 0; k < 6; k++) begin
        s0 = spikes;
        pwm_tick();
        model_tick(f);
        chk("rand_spikes", spikes - s0, f);
        axi_read(32'hC, d);
        chk("rand_pot", d, {8'h0, pot_m[23:0]});
      end
    end

    // Saturation with THRESH=0, then core clear via rst.
    axi_write(32'h0, 32'h1); axi_write(32'h4, 32'hFFFF); axi_write(32'h8, 32'h0);
    s0 = spikes;
    repeat (260) pwm_tick();
    chk("sat_no_spike", spikes - s0, 32'd0);
    axi_read(32'hC, d); chk("sat_pot", d, 32'h00FFFFFF);
    rst = 1'b1;
    @(negedge S_AXI_ACLK);
    rst = 1'b0;
    @(negedge S_AXI_ACLK);
    axi_read(32'hC, d); chk("rst_pot", d, 32'h0);
    axi_read(32'h0, d); chk("rst_keep_ctrl", d, 32'h1);
    axi_read(32'h4, d); chk("rst_keep_weight", d, 32'hFFFF);

    // Async reset in the middle of a read.
    S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("arst_ready_valid", {26'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, digit}, 32'd0);
    chk("arst_rdata", S_AXI_RDATA, 32'd0);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1; S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
    axi_read(32'h4, d); chk("arst_weight", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
